// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch queue between dual fetch and decode.
// Defaults for data width, queue depth and decode issue width live here.
package fetch_queue_pkg;

  localparam int D_WIDTH   = 32;
  localparam int FQ_DEPTH  = 8;
  localparam int FQ_PTR_W  = $clog2(FQ_DEPTH);
  localparam int ISSUE_W   = 2;
  localparam int MAX_ISSUE = 2;

  // Decode may report 3; it can never consume more than a pair.
  function automatic logic [ISSUE_W-1:0] sat_issue(input logic [ISSUE_W-1:0] cnt);
    return (cnt > ISSUE_W'(MAX_ISSUE)) ? ISSUE_W'(MAX_ISSUE) : cnt;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: each entry is {pc, instruction}.
// Two write ports fill a pair at tail/tail+1; two async read ports show head/head+1.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter  int D_WIDTH = fetch_queue_pkg::D_WIDTH,
  parameter  int DEPTH   = FQ_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int E_W     = 2 * D_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [E_W-1:0]   wr_data0,
  input  logic [E_W-1:0]   wr_data1,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [E_W-1:0]   rd_data0,
  output logic [E_W-1:0]   rd_data1
);

  logic [E_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;

  // Power-of-two depth lets the +1 wrap for free.
  assign wr_ptr_next = wr_ptr + PTR_W'(1);
  assign rd_ptr_next = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr]      <= wr_data0;
      mem[wr_ptr_next] <= wr_data1;
    end
  end

  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr_next];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead instruction queue: accepts aligned pairs from fetch, presents the
// oldest two to decode, retires 0..2 per cycle and empties on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int D_WIDTH = fetch_queue_pkg::D_WIDTH,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_Valid,
  input  logic [D_WIDTH-1:0]       i_PC,
  input  logic [D_WIDTH-1:0]       i_Instruction1,
  input  logic [D_WIDTH-1:0]       i_Instruction2,
  input  logic                     i_Flush,
  input  logic [ISSUE_W-1:0]       i_IssueCnt,
  output logic                     o_StallF,
  output logic                     o_Valid1,
  output logic                     o_Valid2,
  output logic [D_WIDTH-1:0]       o_Instruction1,
  output logic [D_WIDTH-1:0]       o_Instruction2,
  output logic [D_WIDTH-1:0]       o_PC1,
  output logic [D_WIDTH-1:0]       o_PC2,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int E_W   = 2 * D_WIDTH;

  logic [PTR_W-1:0] head, head_next;
  logic [PTR_W-1:0] tail, tail_next;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] issue_req;
  logic [CNT_W-1:0] pop_n;
  logic             ready;
  logic             push;
  logic [E_W-1:0]   wr_data0, wr_data1;
  logic [E_W-1:0]   rd_data0, rd_data1;

  // Space is judged on the registered count only; a same-cycle pop never
  // makes room for a same-cycle push.
  assign free_slots = CNT_W'(DEPTH) - count;
  assign ready      = free_slots >= CNT_W'(2);
  assign push       = i_Valid && ready && !i_Flush;
  assign issue_req  = CNT_W'(sat_issue(i_IssueCnt));
  assign pop_n      = (issue_req < count) ? issue_req : count;

  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (i_Flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head + pop_n[PTR_W-1:0];
      tail_next  = push ? tail + PTR_W'(2) : tail;
      count_next = count + (push ? CNT_W'(2) : CNT_W'(0)) - pop_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  assign wr_data0 = {i_PC, i_Instruction1};
  assign wr_data1 = {i_PC + D_WIDTH'(4), i_Instruction2};

  fetch_queue_mem #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_ptr   (tail),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_ptr   (head),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  // Invalid slots read as zero so decode never sees stale entries.
  assign o_Valid1       = count >= CNT_W'(1);
  assign o_Valid2       = count >= CNT_W'(2);
  assign o_PC1          = o_Valid1 ? rd_data0[E_W-1:D_WIDTH] : '0;
  assign o_Instruction1 = o_Valid1 ? rd_data0[D_WIDTH-1:0]   : '0;
  assign o_PC2          = o_Valid2 ? rd_data1[E_W-1:D_WIDTH] : '0;
  assign o_Instruction2 = o_Valid2 ? rd_data1[D_WIDTH-1:0]   : '0;
  assign o_StallF       = !ready;
  assign o_Count        = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pairs enter a model queue and are
// compared against the show-ahead outputs as decode retires them.
module tb_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_Valid;
  logic [DW-1:0] i_PC, i_Instruction1, i_Instruction2;
  logic          i_Flush;
  logic [1:0]    i_IssueCnt;
  logic          o_StallF, o_Valid1, o_Valid2;
  logic [DW-1:0] o_Instruction1, o_Instruction2, o_PC1, o_PC2;
  logic [3:0]    o_Count;

  ent_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_Valid        (i_Valid),
    .i_PC           (i_PC),
    .i_Instruction1 (i_Instruction1),
    .i_Instruction2 (i_Instruction2),
    .i_Flush        (i_Flush),
    .i_IssueCnt     (i_IssueCnt),
    .o_StallF       (o_StallF),
    .o_Valid1       (o_Valid1),
    .o_Valid2       (o_Valid2),
    .o_Instruction1 (o_Instruction1),
    .o_Instruction2 (o_Instruction2),
    .o_PC1          (o_PC1),
    .o_PC2          (o_PC2),
    .o_Count        (o_Count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic valid, input logic [DW-1:0] pc,
                       input logic [DW-1:0] i1, input logic [DW-1:0] i2,
                       input logic flush, input logic [1:0] issue);
    int  pop_n;
    bit  rdy;
    i_Valid = valid; i_PC = pc; i_Instruction1 = i1; i_Instruction2 = i2;
    i_Flush = flush; i_IssueCnt = issue;
    rdy   = (DEPTH - sb.size()) >= 2;
    pop_n = (issue > 2'd2) ? 2 : int'(issue);
    if (pop_n > sb.size()) pop_n = sb.size();
    @(posedge clk); #1;
    if (flush) sb.delete();
    else begin
      repeat (pop_n) void'(sb.pop_front());
      if (valid && rdy) begin
        sb.push_back('{pc: pc, instr: i1});
        sb.push_back('{pc: pc + 32'd4, instr: i2});
      end
    end
    i_Valid = 1'b0; i_Flush = 1'b0; i_IssueCnt = 2'd0;
  endtask

  task automatic push_pair(input logic [DW-1:0] pc, input logic [1:0] issue);
    cycle(1'b1, pc, 32'hE000_0000 | pc, 32'hE100_0000 | pc, 1'b0, issue);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_Valid = 1'b0; i_PC = '0; i_Instruction1 = '0;
    i_Instruction2 = '0; i_Flush = 1'b0; i_IssueCnt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (o_Count !== 4'd0) begin n_miss++; $display("[TB] FAIL reset_count got %0d want 0", o_Count); end
    n_vec++; if (o_Valid1 !== 1'b0 || o_Valid2 !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_valid got %b%b want 00", o_Valid1, o_Valid2); end
    n_vec++; if (o_StallF !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_stall got %b want 0", o_StallF); end
    n_vec++; if (o_PC1 !== '0 || o_Instruction1 !== '0) begin n_miss++; $display("[TB] FAIL reset_data got %h/%h want 0", o_PC1, o_Instruction1); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_push;
    cycle(1'b1, 32'h100, 32'hE3A00001, 32'hE3A01002, 1'b0, 2'd0);
    n_vec++; if (o_Valid1 !== 1'b1 || o_Valid2 !== 1'b1) begin n_miss++; $display("[TB] FAIL first_valid got %b%b want 11", o_Valid1, o_Valid2); end
    n_vec++; if (o_PC1 !== 32'h100) begin n_miss++; $display("[TB] FAIL first_pc1 got %h want 100", o_PC1); end
    n_vec++; if (o_PC2 !== 32'h104) begin n_miss++; $display("[TB] FAIL first_pc2 got %h want 104", o_PC2); end
    n_vec++; if (o_Instruction1 !== 32'hE3A00001 || o_Instruction2 !== 32'hE3A01002) begin n_miss++; $display("[TB] FAIL first_instr got %h/%h want E3A00001/E3A01002", o_Instruction1, o_Instruction2); end
    n_vec++; if (o_Count !== 4'd2) begin n_miss++; $display("[TB] FAIL first_count got %0d want 2", o_Count); end
  endtask

  task automatic test_fill;
    for (int k = 1; k <= 3; k++) begin
      push_pair(32'h100 + 32'(k * 8), 2'd0);
      n_vec++; if (o_Count !== 4'(sb.size())) begin n_miss++; $display("[TB] FAIL fill_count got %0d want %0d", o_Count, sb.size()); end
      n_vec++; if (o_StallF !== ((DEPTH - sb.size()) < 2)) begin n_miss++; $display("[TB] FAIL fill_stall got %b at count %0d", o_StallF, sb.size()); end
    end
    push_pair(32'hDEAD_0000, 2'd0);
    n_vec++; if (o_Count !== 4'd8) begin n_miss++; $display("[TB] FAIL full_ignore_count got %0d want 8", o_Count); end
    n_vec++; if (o_StallF !== 1'b1) begin n_miss++; $display("[TB] FAIL full_stall got %b want 1", o_StallF); end
  endtask

  task automatic test_full_pop;
    n_vec++; if (o_PC1 !== sb[0].pc || o_PC2 !== sb[1].pc) begin n_miss++; $display("[TB] FAIL full_head got %h/%h want %h/%h", o_PC1, o_PC2, sb[0].pc, sb[1].pc); end
    push_pair(32'hBEEF_0000, 2'd2);
    n_vec++; if (o_Count !== 4'd6) begin n_miss++; $display("[TB] FAIL full_pop_count got %0d want 6", o_Count); end
    n_vec++; if (o_StallF !== 1'b0) begin n_miss++; $display("[TB] FAIL full_pop_stall got %b want 0", o_StallF); end
    push_pair(32'h120, 2'd0);
    n_vec++; if (o_Count !== 4'd8) begin n_miss++; $display("[TB] FAIL wrap_count got %0d want 8", o_Count); end
  endtask

  task automatic test_single_issue;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (o_PC1 !== sb[0].pc || o_Instruction1 !== sb[0].instr || o_PC2 !== sb[1].pc || o_Instruction2 !== sb[1].instr) begin n_miss++; $display("[TB] FAIL drain_pair got %h/%h want %h/%h", o_PC1, o_PC2, sb[0].pc, sb[1].pc); end
      cycle(1'b0, '0, '0, '0, 1'b0, (k == 2) ? 2'd1 : 2'd2);
    end
    n_vec++; if (o_Count !== 4'd3) begin n_miss++; $display("[TB] FAIL odd_count got %0d want 3", o_Count); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (o_Valid1 !== 1'b1 || o_PC1 !== sb[0].pc || o_Instruction1 !== sb[0].instr) begin n_miss++; $display("[TB] FAIL single_head got %b %h want 1 %h", o_Valid1, o_PC1, sb[0].pc); end
      n_vec++; if (o_Valid2 !== (sb.size() >= 2) || o_PC2 !== ((sb.size() >= 2) ? sb[1].pc : 32'h0)) begin n_miss++; $display("[TB] FAIL single_second got %b %h with %0d entries", o_Valid2, o_PC2, sb.size()); end
      cycle(1'b0, '0, '0, '0, 1'b0, 2'd1);
    end
    n_vec++; if (o_Count !== 4'd0 || o_Valid1 !== 1'b0) begin n_miss++; $display("[TB] FAIL single_empty got %0d/%b want 0/0", o_Count, o_Valid1); end
  endtask

  task automatic test_clamp;
    cycle(1'b0, '0, '0, '0, 1'b0, 2'd2);
    n_vec++; if (o_Count !== 4'd0) begin n_miss++; $display("[TB] FAIL clamp_empty got %0d want 0", o_Count); end
    push_pair(32'h200, 2'd3);
    n_vec++; if (o_Count !== 4'd2 || o_PC1 !== 32'h200) begin n_miss++; $display("[TB] FAIL clamp_push got %0d %h want 2 200", o_Count, o_PC1); end
    cycle(1'b0, '0, '0, '0, 1'b0, 2'd3);
    n_vec++; if (o_Count !== 4'd0) begin n_miss++; $display("[TB] FAIL clamp_three got %0d want 0", o_Count); end
    push_pair(32'h300, 2'd0);
    cycle(1'b0, '0, '0, '0, 1'b0, 2'd1);
    n_vec++; if (o_PC1 !== 32'h304 || o_Valid2 !== 1'b0 || o_PC2 !== 32'h0) begin n_miss++; $display("[TB] FAIL clamp_one got %h %b %h want 304 0 0", o_PC1, o_Valid2, o_PC2); end
    cycle(1'b0, '0, '0, '0, 1'b0, 2'd2);
    n_vec++; if (o_Count !== 4'(sb.size())) begin n_miss++; $display("[TB] FAIL clamp_over got %0d want %0d", o_Count, sb.size()); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) push_pair(32'h400 + 32'(k * 8), 2'd0);
    cycle(1'b0, '0, '0, '0, 1'b0, 2'd1);
    n_vec++; if (o_Count !== 4'd5) begin n_miss++; $display("[TB] FAIL pre_flush got %0d want 5", o_Count); end
    cycle(1'b1, 32'h900, 32'h1, 32'h2, 1'b1, 2'd2);
    n_vec++; if (o_Count !== 4'd0 || o_Valid1 !== 1'b0 || o_Valid2 !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_state got %0d %b%b want 0 00", o_Count, o_Valid1, o_Valid2); end
    n_vec++; if (o_PC1 !== '0 || o_PC2 !== '0 || o_Instruction1 !== '0 || o_Instruction2 !== '0) begin n_miss++; $display("[TB] FAIL flush_data got %h %h %h %h want 0", o_PC1, o_PC2, o_Instruction1, o_Instruction2); end
    n_vec++; if (o_StallF !== 1'b0) begin n_miss++; $display("[TB] FAIL flush_stall got %b want 0", o_StallF); end
    push_pair(32'h500, 2'd0);
    n_vec++; if (o_PC1 !== 32'h500 || o_Count !== 4'd2) begin n_miss++; $display("[TB] FAIL post_flush got %h %0d want 500 2", o_PC1, o_Count); end
  endtask

  task automatic test_async_reset;
    push_pair(32'h600, 2'd0);
    push_pair(32'h608, 2'd0);
    n_vec++; if (o_Count !== 4'd6) begin n_miss++; $display("[TB] FAIL pre_reset got %0d want 6", o_Count); end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++; if (o_Count !== 4'd0 || o_Valid1 !== 1'b0) begin n_miss++; $display("[TB] FAIL async_reset got %0d/%b want 0/0", o_Count, o_Valid1); end
    n_vec++; if (o_PC1 !== '0) begin n_miss++; $display("[TB] FAIL async_reset_pc got %h want 0", o_PC1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_first_push();
    test_fill();
    test_full_pop();
    test_single_issue();
    test_clamp();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
